signal_discrim_vote: RTL and testbench

// - Next-generation modulation classifier: latches amplitude/frequency feature flags, classifies CW/AM/FM/ASK/FSK/PSK,

---
 rtl/signal_discrim_vote.sv | 105 ++++++++++
 tb/tb_signal_discrim_vote.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/signal_discrim_vote.sv
// signal_discrim_vote: modulation classifier publishing a type only after CONFIRM_N identical decisions
module signal_discrim_vote #(
  parameter int IO_width      = 14,
  parameter int CONFIRM_N     = 3,
  parameter int TIMEOUT       = 2**20,
  parameter int CLEAR_ON_MEAS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       meas_trigger,
  input  logic                       judge_trigger,
  input  logic                       A_const,
  input  logic                       A_square,
  input  logic signed [IO_width-1:0] A_edge_interv,
  input  logic                       F_const,
  input  logic                       F_square,
  input  logic signed [IO_width-1:0] psk_thresh,
  output logic [2:0]                 raw_type,
  output logic                       raw_valid,
  output logic [2:0]                 signal_type,
  output logic                       type_update,
  output logic [3:0]                 run_cnt,
  output logic                       busy,
  output logic                       timeout
);
  typedef enum logic [1:0] {IDLE, MEAS, LATCH, DECIDE} state_t;
  localparam logic [2:0] CW = 3'b000, AM = 3'b001, FM = 3'b010, NA = 3'b100;
  localparam logic [2:0] ASK = 3'b101, FSK = 3'b110, PSK = 3'b111;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] CN = 4'(CONFIRM_N);
  state_t state_q;
  logic [TW-1:0] timer_q;
  logic a_const_q, a_square_q, f_const_q, f_square_q;
  logic signed [IO_width-1:0] interv_q, thresh_q;
  logic [2:0] raw_type_q, sig_q, cand_q, dec_d;
  logic [3:0] run_q, run_d;
  logic [4:0] inc;
  logic raw_valid_q, upd_q, to_q, psk;
  always_comb begin
    psk = !interv_q[IO_width-1] && (interv_q <= thresh_q);
    dec_d = psk ? PSK : !a_const_q ? (a_square_q ? ASK : AM) : !f_const_q ? (f_square_q ? FSK : FM) : CW;
    inc = {1'b0, run_q} + 5'd1;
    run_d = (dec_d != cand_q) ? 4'd1 : (inc >= {1'b0, CN}) ? CN : inc[3:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      {a_const_q, a_square_q, f_const_q, f_square_q} <= '0;
      interv_q <= '0;
      thresh_q <= '0;
      raw_type_q <= NA;
      sig_q <= NA;
      cand_q <= NA;
      run_q <= '0;
      {raw_valid_q, upd_q, to_q} <= '0;
    end else begin
      {raw_valid_q, upd_q, to_q} <= '0;
      // a new window always wins, discarding any decision in flight
      if (meas_trigger) begin
        state_q <= MEAS;
        timer_q <= '0;
        if (CLEAR_ON_MEAS != 0) begin
          sig_q <= NA;
          run_q <= '0;
        end
      end else begin
        case (state_q)
          MEAS:
            if (judge_trigger) begin
              state_q <= LATCH;
              {a_const_q, a_square_q, f_const_q, f_square_q} <= {A_const, A_square, F_const, F_square};
              interv_q <= A_edge_interv;
              thresh_q <= psk_thresh;
            end else if (timer_q == T_LAST) begin
              state_q <= IDLE;
              to_q <= 1'b1;
            end else
              timer_q <= timer_q + 1'b1;
          LATCH: state_q <= DECIDE;
          DECIDE: begin
            state_q <= IDLE;
            raw_type_q <= dec_d;
            raw_valid_q <= 1'b1;
            cand_q <= dec_d;
            run_q <= run_d;
            if (run_d == CN) begin
              sig_q <= dec_d;
              upd_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign raw_type = raw_type_q;
  assign raw_valid = raw_valid_q;
  assign signal_type = sig_q;
  assign type_update = upd_q;
  assign run_cnt = run_q;
  assign busy = state_q != IDLE;
  assign timeout = to_q;
endmodule

// File: tb/tb_signal_discrim_vote.sv
// tb_signal_discrim_vote: randomized bench with a decision-history reference model, two DUT configurations
module tb_signal_discrim_vote;
  localparam int W = 14, CN_A = 3, CN_C = 1;
  localparam logic [2:0] T_CW = 3'b000, T_AM = 3'b001, T_FM = 3'b010, T_NA = 3'b100;
  localparam logic [2:0] T_ASK = 3'b101, T_FSK = 3'b110, T_PSK = 3'b111;
  logic clk = 0, rst = 1, meas = 0, judge = 0, ac = 0, a_sq = 0, fc = 0, fs = 0;
  logic signed [W-1:0] iv_s = '0, th_s = '0;
  logic [2:0] rt_a, st_a, rt_c, st_c;
  logic [3:0] rc_a, rc_c;
  logic rv_a, tu_a, busy_a, to_a, rv_c, tu_c, busy_c, to_c;
  int checks = 0, errors = 0;
  logic [2:0] hist_a[$], hist_c[$];
  logic [2:0] esig_a = T_NA, esig_c = T_NA;
  int erun_a = 0, erun_c = 0;
  bit eupd_a = 0, eupd_c = 0;
  always #5 clk = ~clk;
  // dut_a holds the published type across windows; dut_c clears on every new window and publishes at once
  signal_discrim_vote #(.IO_width(W), .CONFIRM_N(CN_A), .TIMEOUT(16), .CLEAR_ON_MEAS(0)) dut_a (
    .clk(clk), .rst(rst), .meas_trigger(meas), .judge_trigger(judge), .A_const(ac), .A_square(a_sq),
    .A_edge_interv(iv_s), .F_const(fc), .F_square(fs), .psk_thresh(th_s), .raw_type(rt_a), .raw_valid(rv_a),
    .signal_type(st_a), .type_update(tu_a), .run_cnt(rc_a), .busy(busy_a), .timeout(to_a));
  signal_discrim_vote #(.IO_width(W), .CONFIRM_N(CN_C), .TIMEOUT(16), .CLEAR_ON_MEAS(1)) dut_c (
    .clk(clk), .rst(rst), .meas_trigger(meas), .judge_trigger(judge), .A_const(ac), .A_square(a_sq),
    .A_edge_interv(iv_s), .F_const(fc), .F_square(fs), .psk_thresh(th_s), .raw_type(rt_c), .raw_valid(rv_c),
    .signal_type(st_c), .type_update(tu_c), .run_cnt(rc_c), .busy(busy_c), .timeout(to_c));
  function automatic logic [2:0] ref_dec(input bit a_c, a_s, f_c, f_s, input int iv, th);
    if (iv >= 0 && iv <= th) return T_PSK;
    if (!a_c) return a_s ? T_ASK : T_AM;
    if (!f_c) return f_s ? T_FSK : T_FM;
    return T_CW;
  endfunction
  // length of the run of identical decisions ending at the newest one, capped
  function automatic int trail(input logic [2:0] q[$], input int cap);
    int n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != q[q.size()-1] || n == cap) break;
      n++;
    end
    return n;
  endfunction
  task automatic model_reset();
    hist_a.delete(); hist_c.delete();
    esig_a = T_NA; esig_c = T_NA; erun_a = 0; erun_c = 0; eupd_a = 0; eupd_c = 0;
  endtask
  task automatic model_meas();
    hist_c.delete(); esig_c = T_NA; erun_c = 0;
  endtask
  task automatic model_decide(input logic [2:0] d);
    hist_a.push_back(d); erun_a = trail(hist_a, CN_A); eupd_a = erun_a == CN_A; if (eupd_a) esig_a = d;
    hist_c.push_back(d); erun_c = trail(hist_c, CN_C); eupd_c = erun_c == CN_C; if (eupd_c) esig_c = d;
  endtask
  task automatic txn(input bit a_c, a_s, f_c, f_s, input int iv, th, input bit jd);
    logic [2:0] d;
    d = ref_dec(a_c, a_s, f_c, f_s, iv, th);
    @(negedge clk) meas = 1;
    @(negedge clk) meas = 0; model_meas();
    judge = 1; ac = a_c; a_sq = a_s; fc = f_c; fs = f_s; iv_s = iv[W-1:0]; th_s = th[W-1:0];
    @(negedge clk) judge = 0;
    ac = 1'($urandom); a_sq = 1'($urandom); fc = 1'($urandom); fs = 1'($urandom);
    iv_s = W'($urandom); th_s = W'($urandom);
    checks++; if ({rv_a, rv_c} !== 2'b00) begin errors++; $display("FAIL raw_valid_latch: got %b want 00", {rv_a, rv_c}); end
    @(negedge clk) judge = jd;
    checks++; if ({rv_a, rv_c} !== 2'b00) begin errors++; $display("FAIL raw_valid_decide: got %b want 00", {rv_a, rv_c}); end
    @(negedge clk) judge = 0; model_decide(d);
    checks++; if ({rv_a, rv_c} !== 2'b11) begin errors++; $display("FAIL raw_valid_pulse: got %b want 11", {rv_a, rv_c}); end
    checks++; if (rt_a !== d) begin errors++; $display("FAIL raw_type_a: got %b want %b", rt_a, d); end
    checks++; if (rt_c !== d) begin errors++; $display("FAIL raw_type_c: got %b want %b", rt_c, d); end
    checks++; if (st_a !== esig_a) begin errors++; $display("FAIL signal_type_a: got %b want %b", st_a, esig_a); end
    checks++; if (st_c !== esig_c) begin errors++; $display("FAIL signal_type_c: got %b want %b", st_c, esig_c); end
    checks++; if (tu_a !== eupd_a) begin errors++; $display("FAIL type_update_a: got %b want %b", tu_a, eupd_a); end
    checks++; if (tu_c !== eupd_c) begin errors++; $display("FAIL type_update_c: got %b want %b", tu_c, eupd_c); end
    checks++; if (rc_a !== erun_a[3:0]) begin errors++; $display("FAIL run_cnt_a: got %0d want %0d", rc_a, erun_a); end
    checks++; if (rc_c !== erun_c[3:0]) begin errors++; $display("FAIL run_cnt_c: got %0d want %0d", rc_c, erun_c); end
    @(negedge clk);
    checks++; if ({rv_a, rv_c, tu_a, tu_c, busy_a, busy_c} !== 6'b0) begin
      errors++; $display("FAIL after_pulse: raw_valid/type_update/busy got %b want 000000", {rv_a, rv_c, tu_a, tu_c, busy_a, busy_c});
    end
  endtask
  // called one cycle after a window opened; the timeout must land exactly 16 cycles after entry
  task automatic wait_window(input string nm);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (to_a !== (k == 16) || to_c !== (k == 16) || busy_a !== (k < 16) || busy_c !== (k < 16) || {rv_a, rv_c} !== 2'b00) begin
        errors++;
        $display("FAIL %s cycle %0d: timeout=%b%b busy=%b%b raw_valid=%b%b, want timeout=%b busy=%b raw_valid=0",
                 nm, k, to_a, to_c, busy_a, busy_c, rv_a, rv_c, k == 16, k < 16);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0; model_reset();
    checks++; if ({rt_a, rt_c, st_a, st_c} !== {4{T_NA}}) begin errors++; $display("FAIL reset_types: got %b want %b", {rt_a, rt_c, st_a, st_c}, {4{T_NA}}); end
    checks++; if ({rc_a, rc_c} !== 8'd0) begin errors++; $display("FAIL reset_run_cnt: got %h want 00", {rc_a, rc_c}); end
    checks++; if ({rv_a, tu_a, busy_a, to_a, rv_c, tu_c, busy_c, to_c} !== 8'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000000", {rv_a, tu_a, busy_a, to_a, rv_c, tu_c, busy_c, to_c});
    end
  endtask
  task automatic test_ask_confirm();
    repeat (3) txn(0, 1, 0, 0, 100, 5, 0);
    checks++; if (st_a !== T_ASK) begin errors++; $display("FAIL ask_confirmed: got %b want %b", st_a, T_ASK); end
  endtask
  task automatic test_no_flip();
    txn(1, 0, 0, 0, 100, 5, 0);
    txn(0, 1, 0, 0, 100, 5, 0);
    checks++; if (st_a !== T_ASK || rc_a !== 4'd1) begin
      errors++; $display("FAIL no_flip: got type=%b run=%0d want type=%b run=1", st_a, rc_a, T_ASK);
    end
  endtask
  task automatic test_psk_boundary();
    int ivs[4] = '{5, 6, -1, 0};
    int ths[4] = '{5, 5, 5, -3};
    logic [2:0] want[4] = '{T_PSK, T_CW, T_CW, T_CW};
    for (int i = 0; i < 4; i++) begin
      txn(1, 0, 1, 0, ivs[i], ths[i], 0);
      checks++; if (rt_a !== want[i]) begin errors++; $display("FAIL psk_case%0d: got %b want %b", i, rt_a, want[i]); end
    end
  endtask
  task automatic test_timeout();
    @(negedge clk) meas = 1;
    @(negedge clk) meas = 0; model_meas();
    wait_window("timeout");
    checks++; if (st_a !== esig_a || st_c !== esig_c || rc_a !== erun_a[3:0]) begin
      errors++; $display("FAIL timeout_hold: got type=%b/%b run=%0d want %b/%b run=%0d", st_a, st_c, rc_a, esig_a, esig_c, erun_a);
    end
  endtask
  task automatic test_abort();
    @(negedge clk) begin meas = 1; judge = 1; ac = 0; a_sq = 1; iv_s = 14'sd100; th_s = 14'sd5; end
    @(negedge clk) begin meas = 0; judge = 0; end
    model_meas();
    wait_window("meas_judge_same");
    txn(0, 0, 0, 0, 50, 5, 1);
    txn(1, 1, 0, 1, 50, 5, 1);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk) meas = 1;
      @(negedge clk) begin meas = 0; judge = 1; ac = 1; fc = 1; end
      @(negedge clk) judge = 0;
      repeat (p) @(negedge clk);
      meas = 1;
      @(negedge clk) meas = 0; model_meas();
      wait_window(p == 0 ? "meas_in_latch" : "meas_in_decide");
    end
  endtask
  task automatic test_clear();
    txn(1, 0, 1, 0, 100, 5, 0);
    @(negedge clk) meas = 1;
    @(negedge clk) meas = 0; model_meas();
    checks++; if (st_c !== T_NA || rc_c !== 4'd0) begin errors++; $display("FAIL clear_on_meas: got type=%b run=%0d want 100 run=0", st_c, rc_c); end
    checks++; if (st_a !== esig_a) begin errors++; $display("FAIL hold_on_meas: got %b want %b", st_a, esig_a); end
    judge = 1; ac = 0; a_sq = 1; iv_s = 14'sd100; th_s = 14'sd5;
    @(negedge clk) judge = 0;
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0; model_reset();
    checks++; if ({rv_a, rv_c, tu_a, tu_c, busy_a, busy_c} !== 6'b0 || {st_a, st_c, rt_a, rt_c} !== {4{T_NA}} || {rc_a, rc_c} !== 8'd0) begin
      errors++; $display("FAIL reset_mid_decide: flags=%b types=%b run=%h want 000000 %b 00",
                         {rv_a, rv_c, tu_a, tu_c, busy_a, busy_c}, {st_a, st_c, rt_a, rt_c}, {rc_a, rc_c}, {4{T_NA}});
    end
    @(negedge clk);
    checks++; if ({rv_a, rv_c} !== 2'b00) begin errors++; $display("FAIL reset_no_pulse: got %b want 00", {rv_a, rv_c}); end
  endtask
  task automatic test_random();
    bit a_c = 0, a_s = 0, f_c = 0, f_s = 0;
    int iv = 0, th = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        {a_c, a_s, f_c, f_s} = 4'($urandom);
        th = int'($urandom_range(0, 40)) - 20;
        iv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8000)) : th + int'($urandom_range(0, 8)) - 4;
      end
      txn(a_c, a_s, f_c, f_s, iv, th, 1'($urandom));
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_ask_confirm();
    test_no_flip();
    test_psk_boundary();
    test_timeout();
    test_abort();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
